// File: rtl/tinyalu_pkg.sv
// Shared types and helpers for the TinyALU command front-end.
//   op_t         : ALU opcodes; encodings 101..111 are illegal
//   cmd_t        : one queued command {a, b, op}
//   ctrl_state_t : sequencer states
//   is_alu_op()  : true for opcodes that need an ALU start/done cycle
//   expected_result() : reference ALU result for a held A/B/op
package tinyalu_pkg;

    typedef enum logic [2:0] {
        NO_OP  = 3'b000,
        ADD_OP = 3'b001,
        AND_OP = 3'b010,
        XOR_OP = 3'b011,
        MUL_OP = 3'b100
    } op_t;

    // op is kept as raw bits so illegal encodings survive the FIFO.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } ctrl_state_t;

    function automatic logic is_alu_op(input logic [2:0] opc);
        return (opc == ADD_OP) || (opc == AND_OP) || (opc == XOR_OP) || (opc == MUL_OP);
    endfunction

    // ADD keeps its carry (9 bits), AND/XOR are 8 bits, MUL is the full product.
    function automatic logic [15:0] expected_result(input logic [7:0] a,
                                                    input logic [7:0] b,
                                                    input logic [2:0] opc);
        logic [15:0] r;
        r = '0;
        case (opc)
            ADD_OP:  r = {7'd0, {1'b0, a} + {1'b0, b}};
            AND_OP:  r = {8'd0, a & b};
            XOR_OP:  r = {8'd0, a ^ b};
            MUL_OP:  r = {8'd0, a} * {8'd0, b};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Synchronous show-ahead FIFO of cmd_t.
//   clk, reset_n      : clock, asynchronous active-low reset (flushes the FIFO)
//   wr_en, wr_data    : push (ignored while full)
//   rd_en, rd_data    : pop (ignored while empty); rd_data is the current head
//   full, empty       : registered status flags
module tinyalu_cmd_fifo
    import tinyalu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic wr_en,
    input  cmd_t wr_data,
    input  logic rd_en,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    cmd_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          do_push;
    logic          do_pop;

    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: storage has no reset; the pointers and flags alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/tinyalu_cmd_ctrl.sv
// TinyALU command front-end: buffers commands, sequences them onto the ALU
// start/done handshake and returns results over a valid/ready response port.
//   clk, reset_n                  : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           : command handshake, cmd_a/cmd_b/cmd_op payload
//   A, B, op, start               : ALU drive, held constant for the whole ISSUE state
//   done, result                  : ALU completion and result
//   rsp_valid/rsp_ready           : response handshake
//   rsp_result, rsp_op, rsp_err   : captured result, opcode, illegal-op/timeout flag
//   rsp_mismatch                  : result disagrees with the reference model
//   busy                          : sequencer active or commands still queued
// Build option: define TINYALU_CTRL_CHECK_EN to build the result checker;
// otherwise rsp_mismatch is tied low.
module tinyalu_cmd_ctrl
    import tinyalu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic [7:0]  A,
    output logic [7:0]  B,
    output logic [2:0]  op,
    output logic        start,
    input  logic        done,
    input  logic [15:0] result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        rsp_mismatch,
    output logic        busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    ctrl_state_t      state;
    ctrl_state_t      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    cmd_t  push_cmd;
    cmd_t  head;
    logic  fifo_full;
    logic  fifo_empty;
    logic  fifo_pop;

    logic [7:0]  a_next;
    logic [7:0]  b_next;
    logic [2:0]  op_next;
    logic        start_next;
    logic        rsp_valid_next;
    logic [15:0] rsp_result_next;
    logic [2:0]  rsp_op_next;
    logic        rsp_err_next;

    // The full flag is a register, so a pop in the same cycle never frees a slot early.
    assign cmd_ready = !fifo_full;
    assign push_cmd  = '{a: cmd_a, b: cmd_b, op: cmd_op};
    assign busy      = (state != ST_IDLE) || !fifo_empty;

    tinyalu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (cmd_valid && cmd_ready),
        .wr_data (push_cmd),
        .rd_en   (fifo_pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // NOTE: every signal written here gets a default first; a missing branch
    // would otherwise infer a latch.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        fifo_pop        = 1'b0;
        a_next          = A;
        b_next          = B;
        op_next         = op;
        start_next      = start;
        rsp_valid_next  = rsp_valid;
        rsp_result_next = rsp_result;
        rsp_op_next     = rsp_op;
        rsp_err_next    = rsp_err;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (is_alu_op(head.op)) begin
                        a_next     = head.a;
                        b_next     = head.b;
                        op_next    = head.op;
                        start_next = 1'b1;
                        cnt_next   = '0;
                        state_next = ST_ISSUE;
                    end else begin
                        // NOP and illegal opcodes answer directly without touching the ALU.
                        rsp_valid_next  = 1'b1;
                        rsp_result_next = '0;
                        rsp_op_next     = head.op;
                        rsp_err_next    = (head.op != NO_OP);
                        state_next      = ST_RESP;
                    end
                end
            end

            ST_ISSUE: begin
                if (done) begin
                    start_next      = 1'b0;
                    rsp_valid_next  = 1'b1;
                    rsp_result_next = result;
                    rsp_op_next     = op;
                    rsp_err_next    = 1'b0;
                    state_next      = ST_RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    // This cycle's increment would reach TIMEOUT: give up on the ALU.
                    start_next      = 1'b0;
                    rsp_valid_next  = 1'b1;
                    rsp_result_next = '0;
                    rsp_op_next     = op;
                    rsp_err_next    = 1'b1;
                    state_next      = ST_RESP;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            A          <= '0;
            B          <= '0;
            op         <= '0;
            start      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_op     <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            A          <= a_next;
            B          <= b_next;
            op         <= op_next;
            start      <= start_next;
            rsp_valid  <= rsp_valid_next;
            rsp_result <= rsp_result_next;
            rsp_op     <= rsp_op_next;
            rsp_err    <= rsp_err_next;
        end
    end

`ifdef TINYALU_CTRL_CHECK_EN
    logic [15:0] exp_result;
    logic        mismatch_q;

    assign exp_result   = expected_result(A, B, op);
    assign rsp_mismatch = mismatch_q;

    // Only a real ALU completion can mismatch; every other entry into RESP clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mismatch_q <= 1'b0;
        end else if (state == ST_ISSUE && done) begin
            mismatch_q <= (result != exp_result);
        end else if (state != ST_RESP && state_next == ST_RESP) begin
            mismatch_q <= 1'b0;
        end
    end
`else
    assign rsp_mismatch = 1'b0;
`endif

endmodule
